// File: rtl/dcache_line_memory_if.sv
// Line-memory port between the data cache and its backing store.
// master: cache (enable/write/addr/data in), slave: memory (ack/data/busy out).
interface dcache_line_memory_if;
  logic         enable_i;
  logic         write_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         ack_o;
  logic [255:0] data_o;
  logic         busy_o;

  modport master (
    output enable_i,
    output write_i,
    output addr_i,
    output data_i,
    input  ack_o,
    input  data_o,
    input  busy_o
  );

  modport slave (
    input  enable_i,
    input  write_i,
    input  addr_i,
    input  data_i,
    output ack_o,
    output data_o,
    output busy_o
  );
endinterface

// File: rtl/dcache_line_memory.sv
// Fixed-latency 256-bit line memory behind the data cache.
// Ports: clk_i, rst_i (async, active-low), bus (slave modport: request in, ack/data/busy out).
module dcache_line_memory #(
  parameter int unsigned LATENCY    = 10,
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  dcache_line_memory_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK
  } state_t;

  localparam int unsigned LINES = 1 << DEPTH_LOG2;
  localparam logic [7:0]  LAST  = 8'(LATENCY - 1);

  state_t                  state;
  state_t                  state_nx;
  logic [7:0]              count;
  logic [7:0]              count_nx;
  logic                    capture;
  logic                    access;

  logic                    wr;
  logic [DEPTH_LOG2-1:0]   idx;
  logic [255:0]            wdata;

  logic                    ack;
  logic                    busy;
  logic [255:0]            rdata;

  logic [255:0]            mem [LINES];

  // Offset bits and alias bits above the array are don't-care.
  logic                    addr_unused;
  assign addr_unused = ^{bus.addr_i[31:DEPTH_LOG2+5],
                         bus.addr_i[4:0]};

  always_comb begin
    state_nx = state;
    count_nx = count;
    capture  = 1'b0;
    access   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.enable_i) begin
          capture  = 1'b1;
          count_nx = 8'd0;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        count_nx = count + 8'd1;
        if (count == LAST) begin
          access   = 1'b1;
          state_nx = ACK;
        end
      end
      ACK: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      count <= 8'd0;
      ack   <= 1'b0;
      busy  <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      ack   <= (state_nx == ACK);
      busy  <= (state_nx != IDLE);
      if (access && !wr) begin
        rdata <= mem[idx];
      end
    end
  end

  // Request is held here so the cache may change its
  // inputs freely once the request has been taken.
  always_ff @(posedge clk_i) begin
    if (capture) begin
      wr    <= bus.write_i;
      idx   <= bus.addr_i[DEPTH_LOG2+4:5];
      wdata <= bus.data_i;
    end
  end

  // Array commits only at completion, so an aborted
  // request never leaves a partial write behind.
  always_ff @(posedge clk_i) begin
    if (access && wr) begin
      mem[idx] <= wdata;
    end
  end

  assign bus.ack_o  = ack;
  assign bus.busy_o = busy;
  assign bus.data_o = rdata;

endmodule

// File: doc/dcache_line_memory.md
Name: dcache_line_memory

Overview:
- Behavioural-synthesizable backing data memory directly downstream of the data cache.
- Serves whole 256-bit cache lines over the cache's memory port: enable/write/address/data in, ack/data out.
- Models a fixed multi-cycle access latency so the cache miss/writeback state machine sees realistic stalls.
- Accepts one request at a time, latches it, counts latency, completes with a single-cycle ack.

Parameters:
- LATENCY, 10, cycles from request capture edge to the edge that raises ack_o; legal range 1..255.
- DEPTH_LOG2, 9, log2 of the number of 256-bit lines (default 512 lines = 16 KiB).

Ports:
- clk_i  input  1  clock, rising-edge.
- rst_i  input  1  reset, asynchronous, active-low.
- enable_i  input  1  request valid; held high by the cache until it sees ack_o.
- write_i  input  1  1 = line write (writeback), 0 = line read (refill).
- addr_i  input  32  byte address; bits [4:0] ignored; line index = addr_i[DEPTH_LOG2+4:5]; upper bits ignored (aliasing).
- data_i  input  256  write line data.
- ack_o  output  1  one-cycle completion strobe.
- data_o  output  256  read line data, valid while ack_o is high for a read.
- busy_o  output  1  high from capture until ack cycle inclusive.

Behaviour:
- Reset (rst_i low, async): state=IDLE, counter=0, ack_o=0, busy_o=0, data_o=0. Array contents are not reset.
- State machine: IDLE, BUSY, ACK.
- IDLE: on a rising edge with enable_i=1:
  - latch write_i, line index, data_i;
  - clear counter; go to BUSY; busy_o=1.
  - enable_i=0: stay in IDLE.
- BUSY:
  - counter increments each edge;
  - at the edge where counter == LATENCY-1, perform the access and go to ACK.
  - Read: data_o <= array[idx].
  - Write: array[idx] <= latched data; data_o unchanged.
- ACK: ack_o=1 for exactly this one cycle, busy_o=1. Next edge → IDLE, ack_o=0.
- Latency: capture at edge E0; ack_o is high in the cycle following edge E(LATENCY). LATENCY=1 means ack in the cycle after the capture cycle.
- Back-to-back: the cache changes state on the ack edge. In IDLE, if enable_i is still high, the new request (e.g. refill after writeback, with write_i now 0) is captured on that edge. There is no re-capture of a completed request, because ACK→IDLE consumes one edge.
- ack_o and data_o are registered outputs; no combinational path from inputs.
- Inputs changing during BUSY/ACK, including enable_i dropping: ignored; the request completes as latched.
- data_o holds the last read line until the next read completion; writes never disturb it.
- Address aliasing: addresses differing only above bit DEPTH_LOG2+4 map to the same line. Unaligned addresses are truncated to the line.
- Reset during BUSY: aborts. No array write occurs, because the write happens only at completion; ack_o=0; state=IDLE.
- Counter width: 8 bits; no wrap, since the exit happens at LATENCY-1.

Test Plan:
- Reset check:
  - stimulus: assert rst_i=0 mid-cycle;
  - required: ack_o=0, busy_o=0, data_o=0 immediately (async), state IDLE.
- Write then read, LATENCY=10:
  - stimulus: write 0xA5..A5 (256b) to addr 0x0000_0040, then read the same address;
  - required: ack_o high exactly 10 cycles after each capture edge, for 1 cycle; read data_o = 0xA5..A5.
- Writeback→refill with enable held:
  - stimulus: write to 0x0000_0400; on the ack edge switch write_i=0 and addr to 0x0000_0800, keeping enable_i high;
  - required: the second request is captured with no idle gap; two distinct ack pulses; 0x800 returns its previously written pattern.
- Aliasing, DEPTH_LOG2=9:
  - stimulus: write 0x1234.. to 0x0000_4000, read 0x0000_0000; then read 0x0000_401F;
  - required: both reads return 0x1234..
- Reset mid-write:
  - stimulus: pre-write pattern P to 0x80; start a write of Q to 0x80; pulse rst_i low at counter=5; then read 0x80;
  - required: the read returns P, and no ack occurs for the aborted request.
- Input churn during BUSY:
  - stimulus: after capturing a read of 0x20, change addr_i, write_i=1 and data_i every cycle;
  - required: data_o = contents of 0x20 at ack, and no line is modified.
